uart_tx_word: RTL and testbench
===============================

# uart_tx_word

Parametrised UART transmitter that serialises multi-byte words from a small internal FIFO onto one TX line. Each word is sent LSB byte first as consecutive 8-bit frames, with optional parity and one or two stop bits. A word-completion strobe is produced for each word. It sits between the core's output/MMIO write path and the board's serial pin, and replaces the single-word, unbuffered transmitter.

## Interface
- `CLK_PER_HALF_BIT`, 434: half bit period in clk cycles; bit period `T = 2*CLK_PER_HALF_BIT`.
- `NBYTES`, 4: bytes per word, 1..8; word width `W = 8*NBYTES`.
- `FIFO_DEPTH`, 4: word FIFO depth, power of two, ≥2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `sdata`  in  W  word to send.
- `ready`  in  1  push request; `sdata` is sampled on the same edge.
- `full`  out  1  FIFO holds `FIFO_DEPTH` words; a push is refused.
- `overflow`  out  1  one-cycle pulse when `ready` arrives while `full` is high.
- `valid`  out  1  one-cycle pulse when the final stop bit of a word completes.
- `tx_busy`  out  1  FSM not IDLE or FIFO non-empty.
- `txd`  out  1  serial line, idle high, registered.

## Operation
- **Push.** Accepted iff `ready && !full`, judged on the registered `full`. A pop in the same cycle does not make room for that push. On acceptance, `sdata` goes to the tail and the count increments. A refused push leaves FIFO contents unchanged and pulses `overflow`.
- **Pop.** Occurs when the FSM is in IDLE (or finishing the last stop of a word) and the FIFO is non-empty. The head word is loaded into a W-bit shift buffer. Simultaneous push and pop leaves the count unchanged.
- **FSM states:**
  - IDLE: `txd`=1; on pop, go to START.
  - START: `txd`=0 for T cycles, then DATA.
  - DATA: 8 bits, `buf[0]` first, each held T cycles; the buffer shifts right by 1 per bit.
  - After bit 7: go to PARITY if `PARITY`≠0, else STOP.
  - PARITY: even parity = XOR of the 8 byte bits; odd parity = its inverse; held T cycles.
  - STOP: `txd`=1.
    - With `STOP_BITS`=2, the first stop bit lasts T cycles.
    - The last stop bit lasts `Ts = (T*9)/10` cycles (integer divide).
  - After the last stop bit: if more bytes remain in the word, go to START with no idle gap. Otherwise pulse `valid` and pop the next word if one is present (START directly, no gap), else go to IDLE.
- **Counters.**
  - Baud counter width is ceil(log2(T)); it is cleared on every state entry.
  - Bit counter is 0..7.
  - Byte counter is 0..NBYTES-1 and wraps to 0 at word end.
- **Reset** (also mid-frame): the FIFO is emptied, the FSM goes to IDLE and all counters clear. Any partial frame is abandoned with no `valid`.

## Timing
- Output values during and immediately after `rst`: `txd`=1, `full`=0, `overflow`=0, `valid`=0, `tx_busy`=0.
- **Latency.** A push accepted at edge t into an empty FIFO with IDLE FSM gives `txd` low from edge t+1. `tx_busy` goes high from edge t+1.
- **Byte frame length.** `(1 + 8 + P + STOP_BITS - 1)*T + Ts` cycles, where P = 1 if parity is enabled, else 0.
- **Word length.** NBYTES × byte frame length.
- **`valid`.** High for exactly the one cycle after the last stop interval ends. On that same edge `txd` either stays 1 or goes 0 for the next word.
- **`full`.** Rises on the edge after the push that fills the FIFO. Falls on the edge after the next pop.
- **`tx_busy`.** Falls on the edge after the final word's last stop bit.

## Test plan
- **Single word.** Settings: H=4 (T=8, Ts=7), no parity, 1 stop. Push 0x44332211.
  - Line shows bytes 0x11, 0x22, 0x33, 0x44, LSB first.
  - Each byte frame is 79 cycles; total 316 cycles.
  - `valid` pulses once, at cycle 317 after the push.
  - `tx_busy` then drops.
- **Parity.** `PARITY`=1, `STOP_BITS`=2, push 0x00000007.
  - Parity bits are 1,0,0,0.
  - Byte frame is 95 cycles.
  - Repeat with `PARITY`=2: parity bits are 0,1,1,1.
- **Back-to-back.** Push 4 words on consecutive cycles.
  - `full` is high after the 4th push.
  - A 5th push pulses `overflow` and is dropped.
  - The four words go out with no idle gap; `valid` pulses 4 times, 316 cycles apart.
- **Push/pop collision.** With FIFO full, assert `ready` on the pop cycle.
  - The push is refused and `overflow` pulses.
  - The count drops to 3.
- **Mid-frame reset.** Assert `rst` during DATA of byte 2.
  - `txd`=1, `tx_busy`=0, `full`=0 next cycle; no `valid`.
  - A following push transmits cleanly from byte 0.
- **NBYTES=1, FIFO_DEPTH=2.** Push 0xA5.
  - Line shows 0, 1,0,1,0,0,1,0,1, then stop.
  - `valid` pulses after 79 cycles.

Source files
------------

// File: rtl/uart_tx_word_if.sv
// Word-transmitter bus: producer-side push handshake plus the serial line and
// status outputs of uart_tx_word.
interface uart_tx_word_if #(
    parameter int NBYTES = 4
) ();
    logic [8*NBYTES-1:0] sdata;
    logic                ready;
    logic                full;
    logic                overflow;
    logic                valid;
    logic                tx_busy;
    logic                txd;

    modport master (
        output sdata,
        output ready,
        input  full,
        input  overflow,
        input  valid,
        input  tx_busy,
        input  txd
    );

    modport slave (
        input  sdata,
        input  ready,
        output full,
        output overflow,
        output valid,
        output tx_busy,
        output txd
    );
endinterface

// File: rtl/uart_tx_word.sv
// Buffered multi-byte UART transmitter. Words are queued in a small FIFO and
// sent LSB byte first as back-to-back 8-bit frames with optional parity and
// one or two stop bits; the last stop bit is shortened to 9/10 of a bit.
module uart_tx_word #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int NBYTES           = 4,
    parameter int FIFO_DEPTH       = 4,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1
) (
    input logic          clk,
    input logic          rst,
    uart_tx_word_if.slave bus
);

    localparam int W      = 8 * NBYTES;
    localparam int T      = 2 * CLK_PER_HALF_BIT;
    localparam int TS     = (T * 9) / 10;
    localparam int BAUD_W = $clog2(T);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(T - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(TS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;  // first of two stop bits, full length
    localparam logic [2:0] S_LAST   = 3'd5;  // final (shortened) stop bit

    localparam logic [2:0] S_STOP_ENTRY = (STOP_BITS == 2) ? S_STOP : S_LAST;

    // Word FIFO
    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;
    logic             full_q;
    logic             overflow_q;

    // Frame sequencer
    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [W-1:0]      shift_buf;
    logic              par_acc;
    logic              txd_q;
    logic              valid_q;
    logic              busy_q;

    logic push;
    logic pop;
    logic baud_done;
    logic word_end;

    // Handshake decisions and end-of-interval detection for the current cycle
    always_comb begin
        push      = bus.ready && !full_q;
        baud_done = (state == S_LAST) ? (baud_cnt == STOP_LAST)
                                      : (baud_cnt == BIT_LAST);
        word_end  = (state == S_LAST) && baud_done && (byte_cnt == BYTE_LAST);
        pop       = (count != '0) && ((state == S_IDLE) || word_end);
        count_nx  = count + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.sdata;
        end
    end

    // FIFO pointers, occupancy, full flag and overflow strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_nx;
            full_q     <= (count_nx == CNT_FULL);
            overflow_q <= bus.ready && full_q;
        end
    end

    // Frame sequencer: drives txd, steps the counters and emits the word strobe.
    // txd is registered alongside the state so each level appears on the edge
    // that enters its interval; parity accumulates as bits are sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_buf <= '0;
            par_acc   <= 1'b0;
            txd_q     <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    txd_q    <= 1'b1;
                    if (pop) begin
                        state     <= S_START;
                        shift_buf <= mem[rd_ptr];
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                S_START: begin
                    if (baud_done) begin
                        state    <= S_DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd_q    <= shift_buf[0];
                        par_acc  <= shift_buf[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_buf <= {1'b0, shift_buf[W-1:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                txd_q <= (PARITY == 2) ? ~par_acc : par_acc;
                            end else begin
                                state <= S_STOP_ENTRY;
                                txd_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            txd_q   <= shift_buf[1];
                            par_acc <= par_acc ^ shift_buf[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (baud_done) begin
                        state    <= S_STOP_ENTRY;
                        baud_cnt <= '0;
                        txd_q    <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_done) begin
                        state    <= S_LAST;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_LAST: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_cnt == BYTE_LAST) begin
                            byte_cnt <= '0;
                            valid_q  <= 1'b1;
                            if (pop) begin
                                state     <= S_START;
                                shift_buf <= mem[rd_ptr];
                                txd_q     <= 1'b0;
                            end else begin
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= S_START;
                            txd_q    <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                    txd_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;
    assign bus.valid    = valid_q;
    assign bus.tx_busy  = busy_q;
    assign bus.txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: four instances cover no parity, even/odd parity with
// two stop bits, and single-byte words with a two-deep FIFO.
module tb_uart_tx_word;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Expected line level per observation index k (k = 0 is just after the
    // push edge) and the k values at which valid must be high.
    bit exp_txd[$];
    int exp_vk[$];

    always #5 clk = ~clk;

    uart_tx_word_if #(.NBYTES(4)) b0 ();
    uart_tx_word_if #(.NBYTES(4)) b1 ();
    uart_tx_word_if #(.NBYTES(4)) b2 ();
    uart_tx_word_if #(.NBYTES(1)) b3 ();

    uart_tx_word #(.CLK_PER_HALF_BIT(4), .NBYTES(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    uart_tx_word #(.CLK_PER_HALF_BIT(4), .NBYTES(4), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    uart_tx_word #(.CLK_PER_HALF_BIT(4), .NBYTES(4), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2))
        u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    uart_tx_word #(.CLK_PER_HALF_BIT(4), .NBYTES(1), .FIFO_DEPTH(2), .PARITY(0), .STOP_BITS(1))
        u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_txd = {};
        exp_txd.push_back(1'b1);
        exp_vk = {};
    endtask

    // Appends one word's line waveform: start, 8 data LSB first, parity, stops.
    task automatic model_word(input logic [63:0] w, input int nb, input int t,
                              input int par, input int stops);
        int         ts;
        logic [7:0] b;
        bit         pb;
        ts = (t * 9) / 10;
        for (int i = 0; i < nb; i++) begin
            b = w[8*i +: 8];
            repeat (t) exp_txd.push_back(1'b0);
            for (int j = 0; j < 8; j++) begin
                repeat (t) exp_txd.push_back(b[j]);
            end
            if (par != 0) begin
                pb = ^b;
                if (par == 2) pb = ~pb;
                repeat (t) exp_txd.push_back(pb);
            end
            if (stops == 2) repeat (t) exp_txd.push_back(1'b1);
            repeat (ts) exp_txd.push_back(1'b1);
        end
        exp_vk.push_back(exp_txd.size());
    endtask

    function automatic bit exp_txd_at(input int k);
        return (k < exp_txd.size()) ? exp_txd[k] : 1'b1;
    endfunction

    function automatic bit exp_valid_at(input int k);
        foreach (exp_vk[i]) begin
            if (exp_vk[i] == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        logic [4:0] obs;
        logic [4:0] want;
        string      names [5];
        names[0] = "busy"; names[1] = "valid"; names[2] = "overflow";
        names[3] = "full"; names[4] = "txd";
        want = 5'b10000;
        rst = 1'b1;
        b0.ready = 1'b1;
        b0.sdata = 32'hDEADBEEF;
        repeat (3) tick();
        obs = {b0.txd, b0.full, b0.overflow, b0.valid, b0.tx_busy};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== want[i]) begin
                errors++;
                $display("FAIL reset_during_%s: got %b expected %b", names[i], obs[i], want[i]);
            end
        end
        b0.ready = 1'b0;
        rst = 1'b0;
        tick();
        obs = {b0.txd, b0.full, b0.overflow, b0.valid, b0.tx_busy};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== want[i]) begin
                errors++;
                $display("FAIL reset_after_%s: got %b expected %b", names[i], obs[i], want[i]);
            end
        end
        tick();
        checks++;
        if (b3.txd !== 1'b1 || b3.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_nb1: txd=%b busy=%b expected txd=1 busy=0", b3.txd, b3.tx_busy);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        int          nbad, first_bad, nval, vfirst, len;
        logic        busy0, busy1, busy_end;
        for (int n = 0; n < 3; n++) begin
            w = (n == 0) ? 32'h44332211 : 32'($urandom);
            model_clear();
            model_word({32'd0, w}, 4, 8, 0, 1);
            len = exp_txd.size();
            b0.sdata = w;
            b0.ready = 1'b1;
            nbad = 0; first_bad = -1; nval = 0; vfirst = -1;
            busy0 = 1'bx; busy1 = 1'bx;
            for (int k = 0; k < len + 3; k++) begin
                tick();
                b0.ready = 1'b0;
                if (b0.txd !== exp_txd_at(k) || b0.valid !== exp_valid_at(k)) begin
                    nbad++;
                    if (first_bad < 0) first_bad = k;
                end
                if (b0.valid === 1'b1) begin
                    nval++;
                    if (vfirst < 0) vfirst = k;
                end
                if (k == 0) busy0 = b0.tx_busy;
                if (k == 1) busy1 = b0.tx_busy;
            end
            busy_end = b0.tx_busy;
            checks++;
            if (nbad != 0) begin
                errors++;
                $display("FAIL single_stream w=%h: %0d bad cycles, first k=%0d, expected 0", w, nbad, first_bad);
            end
            checks++;
            if (vfirst != 317) begin
                errors++;
                $display("FAIL single_valid_cycle w=%h: got %0d expected 317", w, vfirst);
            end
            checks++;
            if (nval != 1) begin
                errors++;
                $display("FAIL single_valid_count w=%h: got %0d expected 1", w, nval);
            end
            checks++;
            if (busy0 !== 1'b0 || busy1 !== 1'b1 || busy_end !== 1'b0) begin
                errors++;
                $display("FAIL single_busy w=%h: k0=%b k1=%b end=%b expected 0 1 0", w, busy0, busy1, busy_end);
            end
            repeat ($urandom_range(1, 5)) tick();
        end
    endtask

    task automatic test_parity();
        int         nbad, first_bad, vfirst, len, bidx;
        logic       txd_o, val_o;
        logic [3:0] pbits;
        for (int p = 1; p <= 2; p++) begin
            pbits = (p == 1) ? 4'b0001 : 4'b1110;
            model_clear();
            model_word(64'h7, 4, 8, p, 2);
            len = exp_txd.size();
            if (p == 1) begin b1.sdata = 32'h7; b1.ready = 1'b1; end
            else        begin b2.sdata = 32'h7; b2.ready = 1'b1; end
            nbad = 0; first_bad = -1; vfirst = -1;
            for (int k = 0; k < len + 3; k++) begin
                tick();
                b1.ready = 1'b0;
                b2.ready = 1'b0;
                txd_o = (p == 1) ? b1.txd : b2.txd;
                val_o = (p == 1) ? b1.valid : b2.valid;
                if (txd_o !== exp_txd_at(k) || val_o !== exp_valid_at(k)) begin
                    nbad++;
                    if (first_bad < 0) first_bad = k;
                end
                if (val_o === 1'b1 && vfirst < 0) vfirst = k;
                if (k >= 1 && (k - 1) % 95 == 76 && (k - 1) / 95 < 4) begin
                    bidx = (k - 1) / 95;
                    checks++;
                    if (txd_o !== pbits[bidx]) begin
                        errors++;
                        $display("FAIL parity%0d_bit byte%0d: got %b expected %b", p, bidx, txd_o, pbits[bidx]);
                    end
                end
            end
            checks++;
            if (nbad != 0) begin
                errors++;
                $display("FAIL parity%0d_stream: %0d bad cycles, first k=%0d, expected 0", p, nbad, first_bad);
            end
            checks++;
            if (vfirst != 381) begin
                errors++;
                $display("FAIL parity%0d_valid_cycle: got %0d expected 381", p, vfirst);
            end
            repeat (3) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [7];
        int          vks[$];
        int          nbad, first_bad, len;
        for (int i = 0; i < 7; i++) w[i] = 32'($urandom);
        model_clear();
        for (int i = 0; i < 5; i++) model_word({32'd0, w[i]}, 4, 8, 0, 1);
        model_word({32'd0, w[6]}, 4, 8, 0, 1);
        len = exp_txd.size();
        b0.sdata = w[0];
        b0.ready = 1'b1;
        nbad = 0; first_bad = -1;
        for (int k = 0; k < len + 3; k++) begin
            tick();
            if (b0.txd !== exp_txd_at(k) || b0.valid !== exp_valid_at(k)) begin
                nbad++;
                if (first_bad < 0) first_bad = k;
            end
            if (b0.valid === 1'b1) vks.push_back(k);
            if (k == 3) begin
                checks++;
                if (b0.full !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full_early: got %b expected 0", b0.full);
                end
            end
            if (k == 4) begin
                checks++;
                if (b0.full !== 1'b1 || b0.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full: full=%b ovf=%b expected full=1 ovf=0", b0.full, b0.overflow);
                end
            end
            if (k == 5 || k == 6) begin
                checks++;
                if (b0.overflow !== (k == 5)) begin
                    errors++;
                    $display("FAIL b2b_overflow k=%0d: got %b expected %b", k, b0.overflow, (k == 5));
                end
            end
            if (k == 317) begin
                checks++;
                if (b0.overflow !== 1'b1 || b0.full !== 1'b0) begin
                    errors++;
                    $display("FAIL collision_refused: ovf=%b full=%b expected ovf=1 full=0", b0.overflow, b0.full);
                end
            end
            if (k == 318) begin
                checks++;
                if (b0.full !== 1'b1 || b0.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL collision_count3: full=%b ovf=%b expected full=1 ovf=0", b0.full, b0.overflow);
                end
            end
            if (k < 5) begin
                b0.sdata = w[k + 1];
                b0.ready = 1'b1;
            end else if (k == 316) begin
                b0.sdata = 32'($urandom);
                b0.ready = 1'b1;
            end else if (k == 317) begin
                b0.sdata = w[6];
                b0.ready = 1'b1;
            end else begin
                b0.ready = 1'b0;
            end
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL b2b_stream: %0d bad cycles, first k=%0d, expected 0", nbad, first_bad);
        end
        checks++;
        if (vks.size() != 6) begin
            errors++;
            $display("FAIL b2b_valid_count: got %0d expected 6", vks.size());
        end
        checks++;
        if (vks.size() < 1 || vks[0] != 317) begin
            errors++;
            $display("FAIL b2b_valid_first: got %0d expected 317", (vks.size() > 0) ? vks[0] : -1);
        end
        for (int i = 1; i < vks.size() && i < 6; i++) begin
            checks++;
            if (vks[i] - vks[i-1] != 316) begin
                errors++;
                $display("FAIL b2b_valid_gap%0d: got %0d expected 316", i, vks[i] - vks[i-1]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_mid_reset();
        logic [31:0] w;
        int          nbad, first_bad, nval, vfirst, len, noisy;
        w = 32'($urandom);
        b0.sdata = w;
        b0.ready = 1'b1;
        for (int k = 0; k < 190; k++) begin
            tick();
            b0.ready = 1'b0;
            if (k == 189) begin
                checks++;
                if (b0.tx_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_busy_before: got %b expected 1", b0.tx_busy);
                end
                rst = 1'b1;
            end
        end
        tick();
        rst = 1'b0;
        checks++;
        if (b0.txd !== 1'b1 || b0.tx_busy !== 1'b0 || b0.full !== 1'b0 || b0.valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: txd=%b busy=%b full=%b valid=%b expected 1 0 0 0",
                     b0.txd, b0.tx_busy, b0.full, b0.valid);
        end
        noisy = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (b0.valid !== 1'b0 || b0.txd !== 1'b1 || b0.tx_busy !== 1'b0) noisy++;
        end
        checks++;
        if (noisy != 0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d active cycles expected 0", noisy);
        end
        w = 32'($urandom);
        model_clear();
        model_word({32'd0, w}, 4, 8, 0, 1);
        len = exp_txd.size();
        b0.sdata = w;
        b0.ready = 1'b1;
        nbad = 0; first_bad = -1; nval = 0; vfirst = -1;
        for (int k = 0; k < len + 3; k++) begin
            tick();
            b0.ready = 1'b0;
            if (b0.txd !== exp_txd_at(k) || b0.valid !== exp_valid_at(k)) begin
                nbad++;
                if (first_bad < 0) first_bad = k;
            end
            if (b0.valid === 1'b1) begin
                nval++;
                if (vfirst < 0) vfirst = k;
            end
        end
        checks++;
        if (nbad != 0 || nval != 1 || vfirst != 317) begin
            errors++;
            $display("FAIL midrst_resume w=%h: bad=%0d first=%0d nvalid=%0d vk=%0d expected 0 -1 1 317",
                     w, nbad, first_bad, nval, vfirst);
        end
        repeat (3) tick();
    endtask

    task automatic test_nbytes1();
        logic [9:0] pat;
        logic [7:0] bb [3];
        int         nbad, first_bad, nval, vfirst, len, j;
        pat = {1'b1, 8'hA5, 1'b0};
        model_clear();
        model_word(64'hA5, 1, 8, 0, 1);
        len = exp_txd.size();
        b3.sdata = 8'hA5;
        b3.ready = 1'b1;
        nbad = 0; first_bad = -1; vfirst = -1;
        for (int k = 0; k < len + 3; k++) begin
            tick();
            b3.ready = 1'b0;
            if (b3.txd !== exp_txd_at(k) || b3.valid !== exp_valid_at(k)) begin
                nbad++;
                if (first_bad < 0) first_bad = k;
            end
            if (b3.valid === 1'b1 && vfirst < 0) vfirst = k;
            if (k >= 1 && (k - 1) % 8 == 4 && (k - 1) / 8 <= 9) begin
                j = (k - 1) / 8;
                checks++;
                if (b3.txd !== pat[j]) begin
                    errors++;
                    $display("FAIL nb1_line bit%0d: got %b expected %b", j, b3.txd, pat[j]);
                end
            end
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL nb1_stream: %0d bad cycles, first k=%0d, expected 0", nbad, first_bad);
        end
        checks++;
        if (vfirst != 80) begin
            errors++;
            $display("FAIL nb1_valid_cycle: got %0d expected 80", vfirst);
        end
        repeat (2) tick();

        for (int i = 0; i < 3; i++) bb[i] = 8'($urandom);
        model_clear();
        for (int i = 0; i < 3; i++) model_word({56'd0, bb[i]}, 1, 8, 0, 1);
        len = exp_txd.size();
        b3.sdata = bb[0];
        b3.ready = 1'b1;
        nbad = 0; first_bad = -1; nval = 0;
        for (int k = 0; k < len + 3; k++) begin
            tick();
            if (b3.txd !== exp_txd_at(k) || b3.valid !== exp_valid_at(k)) begin
                nbad++;
                if (first_bad < 0) first_bad = k;
            end
            if (b3.valid === 1'b1) nval++;
            if (k == 1 || k == 2) begin
                checks++;
                if (b3.full !== (k == 2)) begin
                    errors++;
                    $display("FAIL nb1_full k=%0d: got %b expected %b", k, b3.full, (k == 2));
                end
            end
            if (k < 2) begin
                b3.sdata = bb[k + 1];
                b3.ready = 1'b1;
            end else begin
                b3.ready = 1'b0;
            end
        end
        checks++;
        if (nbad != 0 || nval != 3) begin
            errors++;
            $display("FAIL nb1_b2b: bad=%0d first=%0d nvalid=%0d expected 0 -1 3", nbad, first_bad, nval);
        end
    endtask

    initial begin
        b0.ready = 1'b0; b0.sdata = '0;
        b1.ready = 1'b0; b1.sdata = '0;
        b2.ready = 1'b0; b2.sdata = '0;
        b3.ready = 1'b0; b3.sdata = '0;
        test_reset();
        test_single_word();
        test_parity();
        test_back_to_back();
        test_mid_reset();
        test_nbytes1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
